// File: rtl/arm_fetch_pkg.sv
// Shared widths, reset PC and the allocation-queue entry layout for the fetch sequencer.
package arm_fetch_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              filled;
  } fetch_entry_t;

  // Instructions are word aligned; the low byte-offset bits are dropped.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return addr & ~(ADDR_W'(3));
  endfunction

endpackage

// File: rtl/fetch_alloc_queue.sv
// DEPTH-entry ring: entries are allocated at request issue, filled in order as
// responses return and popped at the head by decode. Flush empties everything.
module fetch_alloc_queue
  import arm_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_i,
  input  logic [ADDR_W-1:0] alloc_pc_i,
  input  logic              fill_i,
  input  logic [INST_W-1:0] fill_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic              full_o,
  output logic [CNT_W-1:0]  pend_cnt_o,
  output logic              head_filled_o,
  output logic [INST_W-1:0] head_inst_o,
  output logic [ADDR_W-1:0] head_pc_o
);

  fetch_entry_t     ent_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] alloc_cnt_q, alloc_cnt_d;
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic [DEPTH-1:0] alloc_hit, fill_hit, pop_hit;
  logic             do_alloc, do_fill, do_pop;

  assign full_o        = (alloc_cnt_q == CNT_W'(DEPTH));
  assign pend_cnt_o    = pend_cnt_q;
  assign head_filled_o = ent_q[head_q].filled;
  assign head_inst_o   = ent_q[head_q].inst;
  assign head_pc_o     = ent_q[head_q].pc;

  // A response with nothing pending is a protocol violation and is dropped here.
  assign do_alloc = alloc_i & ~flush_i & ~full_o;
  assign do_fill  = fill_i & ~flush_i & (pend_cnt_q != '0);
  assign do_pop   = pop_i & ~flush_i & head_filled_o;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign alloc_hit[gi] = do_alloc & (tail_q == PTR_W'(gi));
    assign fill_hit[gi]  = do_fill & (fill_q == PTR_W'(gi));
    assign pop_hit[gi]   = do_pop & (head_q == PTR_W'(gi));
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    fill_d      = fill_q;
    alloc_cnt_d = alloc_cnt_q;
    pend_cnt_d  = pend_cnt_q;
    if (flush_i) begin
      head_d      = '0;
      tail_d      = '0;
      fill_d      = '0;
      alloc_cnt_d = '0;
      pend_cnt_d  = '0;
    end else begin
      if (do_alloc) tail_d = tail_q + PTR_W'(1);
      if (do_fill)  fill_d = fill_q + PTR_W'(1);
      if (do_pop)   head_d = head_q + PTR_W'(1);
      alloc_cnt_d = alloc_cnt_q + CNT_W'(do_alloc) - CNT_W'(do_pop);
      pend_cnt_d  = pend_cnt_q + CNT_W'(do_alloc) - CNT_W'(do_fill);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      fill_q      <= '0;
      alloc_cnt_q <= '0;
      pend_cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_q      <= fill_d;
      alloc_cnt_q <= alloc_cnt_d;
      pend_cnt_q  <= pend_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_i) begin
          ent_q[i].filled <= 1'b0;
        end else begin
          if (alloc_hit[i]) ent_q[i] <= '{pc: alloc_pc_i, inst: '0, filled: 1'b0};
          if (fill_hit[i]) begin
            ent_q[i].inst   <= fill_data_i;
            ent_q[i].filled <= 1'b1;
          end
          // Clearing on pop keeps a stale entry from looking valid once the ring drains.
          if (pop_hit[i]) ent_q[i].filled <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: issues in-order word reads, buffers them with their
// PCs and hands them to decode; a taken branch redirects and squashes the wrong path.
module fetch_controller
  import arm_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned DISC_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DISC_W-1:0] discard_cnt_q, discard_cnt_d;
  logic [DISC_W-1:0] pend_cnt;
  logic              q_full, head_filled;
  logic              issue, drop_rsp, fill_rsp, pop;

  assign imem_req   = rst & ~branch_taken & ~q_full;
  assign imem_addr  = fetch_pc_q;
  assign issue      = imem_req & imem_gnt;
  assign inst_valid = head_filled & ~branch_taken;
  assign pop        = inst_valid & inst_ready;

  // Responses belonging to squashed requests are consumed before any new-path data.
  assign drop_rsp = imem_rvalid & (discard_cnt_q != '0);
  assign fill_rsp = imem_rvalid & (discard_cnt_q == '0);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    discard_cnt_d = discard_cnt_q - DISC_W'(drop_rsp);
    if (branch_taken) begin
      fetch_pc_d = align_pc(branch_addr);
      // Everything issued but not yet returned (after this cycle's response) becomes junk.
      if (fill_rsp && pend_cnt != '0) begin
        discard_cnt_d = discard_cnt_q + pend_cnt - DISC_W'(1);
      end else begin
        discard_cnt_d = discard_cnt_q - DISC_W'(drop_rsp) + pend_cnt;
      end
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      discard_cnt_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  fetch_alloc_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .alloc_i      (issue),
    .alloc_pc_i   (fetch_pc_q),
    .fill_i       (fill_rsp),
    .fill_data_i  (imem_rdata),
    .pop_i        (pop),
    .flush_i      (branch_taken),
    .full_o       (q_full),
    .pend_cnt_o   (pend_cnt),
    .head_filled_o(head_filled),
    .head_inst_o  (inst),
    .head_pc_o    (inst_pc)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: queue-based reference model plus a
// fixed-latency in-order instruction memory, directed scenarios and random traffic.
module tb_fetch_controller;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        branch_taken;
  logic [31:0] branch_addr;

  fetch_controller #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  // Reference model: allocated PCs in order, returned words in order, junk count.
  logic [31:0] pcs[$];
  logic [31:0] data[$];
  mreq_t       mem_q[$];
  int          discard;
  logic [31:0] mpc;
  int          lat;
  int          cyc;
  bit          model_ok;
  int          checks;
  int          errors;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pcs.delete();
    data.delete();
    mem_q.delete();
    discard = 0;
    mpc = 32'h0;
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, advance the model.
  task automatic step(input logic r, input logic g, input logic rdy, input logic br,
                      input logic [31:0] ba);
    logic m_req, m_valid, m_issue, m_pop, m_fill;
    int   pend;
    @(negedge clk);
    rst          = r;
    imem_gnt     = g;
    inst_ready   = rdy;
    branch_taken = br;
    branch_addr  = ba;
    if (r && mem_q.size() > 0 && mem_q[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    s_req   = imem_req;
    s_valid = inst_valid;
    s_addr  = imem_addr;
    s_pc    = inst_pc;
    s_inst  = inst;
    m_req   = r & ~br & (pcs.size() < DEPTH);
    m_valid = (data.size() > 0) & ~br;
    pend    = pcs.size() - data.size();
    if (model_ok) begin
      check("imem_req", {31'b0, s_req}, {31'b0, m_req});
      check("imem_addr", s_addr, mpc);
      check("inst_valid", {31'b0, s_valid}, {31'b0, m_valid});
      if (m_valid) begin
        check("inst_pc", s_pc, pcs[0]);
        check("inst", s_inst, data[0]);
      end
      if (r) assert (mem_q.size() == discard + pend);
    end
    if (!r) begin
      model_reset();
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_issue = m_req & g;
      m_pop   = m_valid & rdy;
      m_fill  = 1'b0;
      if (imem_rvalid) begin
        if (discard > 0) discard--;
        else if (pend > 0) m_fill = 1'b1;
        void'(mem_q.pop_front());
      end
      if (br) begin
        discard += pend - int'(m_fill);
        pcs.delete();
        data.delete();
        mpc = {ba[31:2], 2'b00};
      end else begin
        if (m_pop) begin
          $display("xfer cyc=%0d pc=%08h inst=%08h", cyc, pcs[0], data[0]);
          void'(pcs.pop_front());
          void'(data.pop_front());
        end
        if (m_fill) data.push_back(imem_rdata);
        if (m_issue) begin
          pcs.push_back(mpc);
          mem_q.push_back('{due: cyc + lat, addr: mpc});
          mpc = mpc + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    int issues;
    bit found;
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    checks = 0; errors = 0; cyc = 0; lat = 1; model_ok = 1'b0;
    model_reset();

    // Reset values, then zero-wait streaming: first instruction in the 3rd cycle.
    do_reset(3);
    check("rst imem_req", {31'b0, s_req}, 32'h0);
    check("rst inst_valid", {31'b0, s_valid}, 32'h0);
    check("rst inst", s_inst, 32'h0);
    check("rst inst_pc", s_pc, 32'h0);
    check("rst imem_addr", s_addr, 32'h0);
    lat = 1;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (k == 1) check("lat valid early", {31'b0, s_valid}, 32'h0);
      if (k >= 2 && k <= 5) begin
        check("lat valid", {31'b0, s_valid}, 32'h1);
        check("lat pc", s_pc, 32'((k - 2) * 4));
        check("lat inst", s_inst, mem_word(32'((k - 2) * 4)));
      end
    end

    // Decode stalled: exactly DEPTH issues, then the request drops; head held.
    do_reset(2);
    issues = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      if (s_req) issues++;
      if (k < 4) check("stall addr", s_addr, 32'(k * 4));
    end
    check("stall issues", 32'(issues), 32'd4);
    check("stall req off", {31'b0, s_req}, 32'h0);
    check("stall head valid", {31'b0, s_valid}, 32'h1);
    check("stall head pc", s_pc, 32'h0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Grant every other cycle, 3-cycle response latency, random decode stalls.
    lat = 3;
    for (int k = 0; k < 200; k++) step(1'b1, k[0], ($urandom % 3) != 0, 1'b0, 32'h0);

    // Branch with three requests in flight: their responses are dropped.
    do_reset(2);
    lat = 4;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h103);
    check("br req off", {31'b0, s_req}, 32'h0);
    check("br valid off", {31'b0, s_valid}, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("br target addr", s_addr, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (s_valid) begin
        found = 1'b1;
        check("br first pc", s_pc, 32'h100);
      end
    end
    if (!found) check("br first delivery seen", 32'h0, 32'h1);

    // Branch coinciding with a would-be transfer.
    do_reset(2);
    lat = 1;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
    check("brx valid", {31'b0, s_valid}, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("brx empty1", {31'b0, s_valid}, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("brx empty2", {31'b0, s_valid}, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("brx resume valid", {31'b0, s_valid}, 32'h1);
    check("brx resume pc", s_pc, 32'h200);

    // PC wrap, then reset in the middle of a full queue.
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap addr top", s_addr, 32'hFFFFFFFC);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap addr zero", s_addr, 32'h0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap head pc", s_pc, 32'hFFFFFFFC);
    do_reset(2);
    check("midrst req", {31'b0, s_req}, 32'h0);
    check("midrst valid", {31'b0, s_valid}, 32'h0);
    check("midrst inst", s_inst, 32'h0);
    check("midrst pc", s_pc, 32'h0);
    check("midrst addr", s_addr, 32'h0);

    // Random traffic with branches, back-to-back branches and occasional resets.
    for (int ph = 1; ph <= 2; ph++) begin
      lat = ph;
      for (int k = 0; k < 600; k++) begin
        step(($urandom % 300) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
             ($urandom % 12) == 0, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Instruction-fetch sequencer sitting between the pipeline IF/ID boundary and the word-addressed instruction memory.
- Holds the fetch PC and issues in-order read requests over a req/gnt, rvalid memory handshake.
- Buffers returned instructions with their PCs in a DEPTH-entry allocation queue and presents them to decode with valid/ready.
- On a taken branch, redirects fetch and squashes all wrong-path instructions, both buffered and in flight.

Parameters:
ADDR_W, 32, instruction address width (byte address)
INST_W, 32, instruction width
DEPTH, 4, allocation queue entries (power of 2, >=2); also the cap on outstanding requests
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
imem_req  out  1  read request valid
imem_addr  out  ADDR_W  request byte address, bits [1:0] always 0
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid (in order, earliest the cycle after gnt)
imem_rdata  in  INST_W  read data
inst_valid  out  1  instruction available to decode
inst  out  INST_W  head instruction
inst_pc  out  ADDR_W  byte address of head instruction
inst_ready  in  1  decode accepts head
branch_taken  in  1  redirect request (1-cycle pulse)
branch_addr  in  ADDR_W  redirect target; bits [1:0] ignored

Behaviour:
Reset and clocking:
- Reset is sampled at posedge clk while rst==0.
- Reset state: fetch_pc=RESET_PC; queue empty (alloc_cnt=0, head=tail=fill=0, all entry filled bits 0); discard_cnt=0.
- Reset outputs: imem_req=0, inst_valid=0, inst and inst_pc = 0.

Request issue:
- imem_req = rst & ~branch_taken & (alloc_cnt < DEPTH), combinational.
- imem_addr = fetch_pc.
- Issue occurs when imem_req & imem_gnt. On issue, the tail entry is allocated with pc=fetch_pc and filled=0; tail++; fetch_pc += 4 (modulo 2^ADDR_W, wraps silently).

Response handling:
- Responses return in order.
- If discard_cnt>0, an imem_rvalid decrements discard_cnt and its data is dropped.
- Otherwise an imem_rvalid writes imem_rdata to the entry at fill pointer, sets filled=1, fill++.
- imem_rvalid with no outstanding request is ignored (protocol violation; assertion in bench).

Decode handshake:
- inst_valid = head entry filled & ~branch_taken.
- inst / inst_pc come from head registers, with no bypass from imem_rdata.
- Transfer when inst_valid & inst_ready: head++, alloc_cnt--.
- Issue and pop in the same cycle leave alloc_cnt unchanged.

Branch flush (branch_taken=1, highest priority):
- Next fetch_pc = {branch_addr[ADDR_W-1:2],2'b00}.
- All entries invalidated; head=tail=fill=0; alloc_cnt=0.
- discard_cnt += number of issued-but-unreturned requests, i.e. (tail-fill) minus any rvalid consumed this cycle.
- No issue and no transfer occur in the flush cycle.
- Fetch resumes the next cycle at the target, even while discard_cnt>0.
- discard_cnt width is clog2(DEPTH)+1 and never exceeds DEPTH.
- Back-to-back branch pulses: the last one wins, and discard accumulates correctly.

Latency and throughput:
- With zero-wait memory (gnt=1, rvalid the cycle after), the first inst_valid is in the 3rd cycle after reset release.
- Sustained throughput is 1 instruction/cycle when DEPTH>=3 and inst_ready=1.

Backpressure and reset:
- inst_ready=0 holds the head stable; issue stops once alloc_cnt==DEPTH.
- Reset asserted mid-operation discards everything. In-flight responses after reset are not tracked; memory is reset by the same rst.

Decomposition:
- Package arm_fetch_pkg holds ADDR_W, INST_W, RESET_PC, PC_STEP=4, and a fetch entry struct {pc, inst, filled}.
- One natural sub-module, fetch_alloc_queue: DEPTH-entry ring with separate alloc/fill/pop pointers, alloc_cnt, and flush.
- The top holds fetch_pc, discard_cnt and the handshake glue.

Test Plan:
- Reset release with gnt=1 and 1-cycle rvalid returning the words for 0,4,8,... ; inst_ready=1 -> inst_pc sequence 0,4,8,12 one per cycle from cycle 3; inst matches the memory words.
- inst_ready=0 for 10 cycles -> exactly DEPTH=4 issues (addresses 0..12), then imem_req=0; head inst_pc=0 held stable; on ready=1 the pops resume in order.
- imem_gnt toggled every other cycle and rvalid delayed 3 cycles -> in-order delivery, no loss or duplication, alloc_cnt never exceeds 4.
- branch_taken with branch_addr=0x103 while 3 requests are in flight -> those 3 responses are dropped; next imem_addr=0x100; first delivered inst_pc=0x100.
- Branch in the same cycle as inst_valid & inst_ready -> no transfer counted; inst_valid=0 that cycle; queue empty the next cycle.
- fetch_pc=0xFFFFFFFC with a grant -> next imem_addr=0x00000000; rst=0 mid-stream -> all outputs return to reset values the next cycle.
